cache_assoc_tag_ctrl: RTL and testbench

Parametrised tag/state controller for the set-associative write-back, write-allocate cache that succeeds the direct-mapped datapath. It holds per-set tag, valid, dirty and LRU state for NUM_WAYS ways and returns a registered hit/victim decision through a val/rdy response. It installs refilled lines and runs a flush walker that emits a writeback request for every dirty line. Data arrays and the memory sender/receiver remain outside this block and are driven by the cache control unit.

---
 rtl/cache_assoc_tag_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_cache_assoc_tag_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_tag_ctrl.sv
// rtl/cache_assoc_tag_ctrl.sv - set-associative tag/valid/dirty/LRU controller with flush walker
//
// Holds per-set tag, valid, dirty and age (LRU) state for NUM_WAYS ways and answers
// lookups with a registered hit/victim decision. Installs refilled lines and walks
// every line on a flush, emitting a writeback request for each dirty one.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   lkup_val/rdy/addr/write       lookup request (write sets dirty on a hit)
//   res_val/rdy/hit/way           registered lookup result (hit way or victim way)
//   res_victim_dirty/addr         victim state and line-aligned address
//   fill_val/rdy/addr/way/dirty   line install request
//   flush_req/busy/done           flush control and status
//   wb_val/rdy/addr/way           writeback request issued by the flush walker
//
// Build option: define FLUSH_INVALIDATE_EN to make the flush invalidate every line it
// visits and reset each set's ages; otherwise the flush only cleans dirty lines.
module cache_assoc_tag_ctrl #(
    parameter  int NUM_WAYS   = 2,
    parameter  int NUM_SETS   = 32,
    parameter  int ADDR_W     = 32,
    parameter  int LINE_BYTES = 64,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int IDX_W      = $clog2(NUM_SETS),
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lkup_val,
    output logic              lkup_rdy,
    input  logic [ADDR_W-1:0] lkup_addr,
    input  logic              lkup_write,
    output logic              res_val,
    input  logic              res_rdy,
    output logic              res_hit,
    output logic [WAY_W-1:0]  res_way,
    output logic              res_victim_dirty,
    output logic [ADDR_W-1:0] res_victim_addr,
    input  logic              fill_val,
    output logic              fill_rdy,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [WAY_W-1:0]  fill_way,
    input  logic              fill_dirty,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done,
    output logic              wb_val,
    input  logic              wb_rdy,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WAY_W-1:0]  wb_way
);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;
    state_t state_q, state_d;

    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

    logic [IDX_W-1:0] set_cnt;
    logic [WAY_W-1:0] way_cnt;
    logic             pend_q;
    logic             fl_start, fl_adv, fl_wb_acc, last_line;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_W-1:0] i);
        return (ADDR_W'(t) << (IDX_W + OFF_W)) | (ADDR_W'(i) << OFF_W);
    endfunction

    logic [TAG_W-1:0] lkup_tag, fill_tag;
    logic [IDX_W-1:0] lkup_idx, fill_idx;
    logic             unused_offset;
    assign lkup_tag = lkup_addr[ADDR_W-1:OFF_W+IDX_W];
    assign lkup_idx = lkup_addr[OFF_W+IDX_W-1:OFF_W];
    assign fill_tag = fill_addr[ADDR_W-1:OFF_W+IDX_W];
    assign fill_idx = fill_addr[OFF_W+IDX_W-1:OFF_W];
    assign unused_offset = ^{lkup_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

    logic lkup_acc, fill_acc;
    assign fill_rdy = !flush_busy;
    assign lkup_rdy = !flush_busy && !fill_val && (!res_val || res_rdy);
    assign lkup_acc = lkup_val && lkup_rdy;
    assign fill_acc = fill_val && fill_rdy;

    // Hit search and victim choice for the addressed set. Ages are a permutation,
    // so the way holding age NUM_WAYS-1 is the least recently used one.
    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, old_way, victim_way, sel_way;
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[lkup_idx][w] && tag_q[lkup_idx][w] == lkup_tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[lkup_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[lkup_idx][w] == LAST_WAY) old_way = WAY_W'(w);
        end
        victim_way = inv_found ? inv_way : old_way;
        sel_way    = hit ? hit_way : victim_way;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_val          <= 1'b0;
            res_hit          <= 1'b0;
            res_way          <= '0;
            res_victim_dirty <= 1'b0;
            res_victim_addr  <= '0;
        end else if (lkup_acc) begin
            res_val          <= 1'b1;
            res_hit          <= hit;
            res_way          <= sel_way;
            res_victim_dirty <= !hit && valid_q[lkup_idx][victim_way] && dirty_q[lkup_idx][victim_way];
            res_victim_addr  <= line_addr(tag_q[lkup_idx][sel_way], lkup_idx);
        end else if (res_rdy) begin
            res_val <= 1'b0;
        end
    end

    // Fill and lookup can never both be accepted, and neither is accepted while the
    // flush walker runs, so each set sees at most one writer per cycle.
    logic             touch_en;
    logic [IDX_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    assign touch_en  = fill_acc || (lkup_acc && hit);
    assign touch_set = fill_acc ? fill_idx : lkup_idx;
    assign touch_way = fill_acc ? fill_way : hit_way;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (touch_en) begin
                for (int w = 0; w < NUM_WAYS; w++)
                    if (age_q[touch_set][w] < age_q[touch_set][touch_way])
                        age_q[touch_set][w] <= age_q[touch_set][w] + WAY_W'(1);
                age_q[touch_set][touch_way] <= '0;
            end
            if (fill_acc) begin
                tag_q[fill_idx][fill_way]   <= fill_tag;
                valid_q[fill_idx][fill_way] <= 1'b1;
                dirty_q[fill_idx][fill_way] <= fill_dirty;
            end
            if (lkup_acc && hit && lkup_write) dirty_q[lkup_idx][hit_way] <= 1'b1;
            if (fl_wb_acc) dirty_q[set_cnt][way_cnt] <= 1'b0;
`ifdef FLUSH_INVALIDATE_EN
            if (fl_adv) begin
                valid_q[set_cnt][way_cnt] <= 1'b0;
                if (way_cnt == LAST_WAY)
                    for (int w = 0; w < NUM_WAYS; w++) age_q[set_cnt][w] <= WAY_W'(w);
            end
`endif
        end
    end

    assign last_line = (set_cnt == LAST_SET) && (way_cnt == LAST_WAY);
    assign wb_addr   = line_addr(tag_q[set_cnt][way_cnt], set_cnt);
    assign wb_way    = way_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fl_start   = 1'b0;
        fl_adv     = 1'b0;
        fl_wb_acc  = 1'b0;
        flush_busy = (state_q != S_IDLE);
        flush_done = 1'b0;
        wb_val     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Wait for an outstanding result to drain before walking the tags.
                if ((pend_q || flush_req) && !res_val) begin
                    fl_start = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (valid_q[set_cnt][way_cnt] && dirty_q[set_cnt][way_cnt]) begin
                    state_d = S_WB;
                end else begin
                    fl_adv = 1'b1;
                    if (last_line) state_d = S_DONE;
                end
            end
            S_WB: begin
                wb_val = 1'b1;
                if (wb_rdy) begin
                    fl_wb_acc = 1'b1;
                    fl_adv    = 1'b1;
                    state_d   = last_line ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                flush_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= 1'b0;
            set_cnt <= '0;
            way_cnt <= '0;
        end else begin
            if (state_q == S_IDLE) pend_q <= (pend_q || flush_req) && !fl_start;
            if (fl_start) begin
                set_cnt <= '0;
                way_cnt <= '0;
            end else if (fl_adv) begin
                if (way_cnt == LAST_WAY) begin
                    way_cnt <= '0;
                    set_cnt <= set_cnt + IDX_W'(1);
                end else begin
                    way_cnt <= way_cnt + WAY_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_assoc_tag_ctrl.sv
// tb/tb_cache_assoc_tag_ctrl.sv - directed self-checking bench for cache_assoc_tag_ctrl
module tb_cache_assoc_tag_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lkup_val = 1'b0, lkup_rdy, lkup_write = 1'b0;
    logic [31:0] lkup_addr = '0;
    logic        res_val, res_rdy = 1'b0, res_hit, res_victim_dirty;
    logic [0:0]  res_way;
    logic [31:0] res_victim_addr;
    logic        fill_val = 1'b0, fill_rdy, fill_dirty = 1'b0;
    logic [31:0] fill_addr = '0;
    logic [0:0]  fill_way = '0;
    logic        flush_req = 1'b0, flush_busy, flush_done;
    logic        wb_val, wb_rdy = 1'b0;
    logic [31:0] wb_addr;
    logic [0:0]  wb_way;

    int checks = 0;
    int errors = 0;
    logic [31:0] wb_log [4];
    logic [0:0]  wb_way_log [4];
    int wb_n, done_n, busy_n;

    always #5 clk = ~clk;

    cache_assoc_tag_ctrl dut (
        .clk(clk), .reset(reset),
        .lkup_val(lkup_val), .lkup_rdy(lkup_rdy), .lkup_addr(lkup_addr), .lkup_write(lkup_write),
        .res_val(res_val), .res_rdy(res_rdy), .res_hit(res_hit), .res_way(res_way),
        .res_victim_dirty(res_victim_dirty), .res_victim_addr(res_victim_addr),
        .fill_val(fill_val), .fill_rdy(fill_rdy), .fill_addr(fill_addr), .fill_way(fill_way),
        .fill_dirty(fill_dirty),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_addr(wb_addr), .wb_way(wb_way)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_fill(input logic [31:0] addr, input logic [0:0] way, input logic dirty);
        fill_addr = addr; fill_way = way; fill_dirty = dirty; fill_val = 1'b1;
        tick();
        fill_val = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] addr, input logic wr);
        lkup_addr = addr; lkup_write = wr; lkup_val = 1'b1;
        tick();
        lkup_val = 1'b0; lkup_write = 1'b0;
    endtask

    task automatic pop();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
    endtask

    task automatic run_flush(input int stall_n, input int budget);
        int stall;
        stall = 0; wb_n = 0; done_n = 0; busy_n = 0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (flush_busy) busy_n++;
            if (flush_done) done_n++;
            if (wb_val) begin
                if (stall < stall_n) begin
                    stall++;
                    wb_rdy = 1'b0;
                end else begin
                    if (wb_n < 4) begin
                        wb_log[wb_n] = wb_addr;
                        wb_way_log[wb_n] = wb_way;
                    end
                    wb_n++;
                    stall = 0;
                    wb_rdy = 1'b1;
                end
            end else begin
                wb_rdy = 1'b0;
            end
            if (done_n > 0 && !flush_busy) break;
            tick();
        end
        wb_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL reset_res_val got %b want 0", res_val); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy got %b want 0", flush_busy); end
        checks++; if (wb_val !== 1'b0) begin errors++; $display("FAIL reset_wb_val got %b want 0", wb_val); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
        reset = 1'b0;
        tick();
        checks++; if (lkup_rdy !== 1'b1) begin errors++; $display("FAIL reset_lkup_rdy got %b want 1", lkup_rdy); end
        checks++; if (fill_rdy !== 1'b1) begin errors++; $display("FAIL reset_fill_rdy got %b want 1", fill_rdy); end
    endtask

    task automatic test_lookup_miss();
        do_lookup(32'h0000_1040, 1'b0);
        checks++; if (res_val !== 1'b1) begin errors++; $display("FAIL miss_res_val got %b want 1", res_val); end
        checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b want 0", res_hit); end
        checks++; if (res_way !== 1'b0) begin errors++; $display("FAIL miss_way got %0d want 0", res_way); end
        checks++; if (res_victim_dirty !== 1'b0) begin errors++; $display("FAIL miss_vdirty got %b want 0", res_victim_dirty); end
        pop();
        checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL miss_pop_res_val got %b want 0", res_val); end
    endtask

    task automatic test_hit_victim();
        do_fill(32'h0000_1040, 1'b0, 1'b0);
        do_lookup(32'h0000_1044, 1'b1);
        checks++; if (res_hit !== 1'b1) begin errors++; $display("FAIL hitw_hit got %b want 1", res_hit); end
        checks++; if (res_way !== 1'b0) begin errors++; $display("FAIL hitw_way got %0d want 0", res_way); end
        pop();
        do_fill(32'h0000_2040, 1'b1, 1'b0);
        do_lookup(32'h0000_3040, 1'b0);
        checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL victim_hit got %b want 0", res_hit); end
        checks++; if (res_way !== 1'b0) begin errors++; $display("FAIL victim_way got %0d want 0", res_way); end
        checks++; if (res_victim_dirty !== 1'b1) begin errors++; $display("FAIL victim_dirty got %b want 1", res_victim_dirty); end
        checks++; if (res_victim_addr !== 32'h0000_1040) begin errors++; $display("FAIL victim_addr got %h want 00001040", res_victim_addr); end
        pop();
    endtask

    task automatic test_backpressure();
        lkup_addr = 32'h0000_2040; lkup_val = 1'b1; res_rdy = 1'b0;
        tick();
        lkup_addr = 32'h0000_1040;
        for (int i = 0; i < 3; i++) begin
            checks++; if (lkup_rdy !== 1'b0) begin errors++; $display("FAIL bp_lkup_rdy[%0d] got %b want 0", i, lkup_rdy); end
            checks++; if (res_val !== 1'b1) begin errors++; $display("FAIL bp_res_val[%0d] got %b want 1", i, res_val); end
            checks++; if (res_hit !== 1'b1 || res_way !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got hit %b way %0d want hit 1 way 1", i, res_hit, res_way); end
            tick();
        end
        res_rdy = 1'b1;
        #1;
        checks++; if (lkup_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", lkup_rdy); end
        tick();
        checks++; if (res_val !== 1'b1 || res_hit !== 1'b1 || res_way !== 1'b0) begin errors++; $display("FAIL bp_next got val %b hit %b way %0d want 1 1 0", res_val, res_hit, res_way); end
        lkup_val = 1'b0;
        tick();
        checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", res_val); end
        res_rdy = 1'b0;
    endtask

    task automatic test_flush();
        logic exp_hit;
`ifdef FLUSH_INVALIDATE_EN
        exp_hit = 1'b0;
`else
        exp_hit = 1'b1;
`endif
        do_fill(32'h0000_2140, 1'b0, 1'b1);
        run_flush(2, 300);
        checks++; if (wb_n !== 2) begin errors++; $display("FAIL flush_wb_count got %0d want 2", wb_n); end
        checks++; if (wb_log[0] !== 32'h0000_1040) begin errors++; $display("FAIL flush_wb0 got %h want 00001040", wb_log[0]); end
        checks++; if (wb_log[1] !== 32'h0000_2140) begin errors++; $display("FAIL flush_wb1 got %h want 00002140", wb_log[1]); end
        checks++; if (wb_way_log[0] !== 1'b0 || wb_way_log[1] !== 1'b0) begin errors++; $display("FAIL flush_wb_way got %0d %0d want 0 0", wb_way_log[0], wb_way_log[1]); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL flush_done_count got %0d want 1", done_n); end
        checks++; if (busy_n !== 71) begin errors++; $display("FAIL flush_busy_cycles got %0d want 71", busy_n); end
        do_lookup(32'h0000_2040, 1'b0);
        checks++; if (res_hit !== exp_hit) begin errors++; $display("FAIL postflush_hit got %b want %b", res_hit, exp_hit); end
        pop();
        do_lookup(32'h0000_3040, 1'b0);
        checks++; if (res_hit !== 1'b0 || res_way !== 1'b0) begin errors++; $display("FAIL postflush_miss got hit %b way %0d want 0 0", res_hit, res_way); end
        checks++; if (res_victim_dirty !== 1'b0) begin errors++; $display("FAIL postflush_vdirty got %b want 0", res_victim_dirty); end
        pop();
    endtask

    task automatic test_reset_mid_flush();
        int seen_wb, seen_done;
        do_reset();
        do_fill(32'h0000_1040, 1'b0, 1'b1);
        wb_rdy = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 20 && !wb_val; c++) tick();
        checks++; if (wb_val !== 1'b1) begin errors++; $display("FAIL midrst_reach_wb got %b want 1", wb_val); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (wb_val !== 1'b0) begin errors++; $display("FAIL midrst_wb_val got %b want 0", wb_val); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", flush_busy); end
        tick();
        tick();
        reset = 1'b0;
        seen_wb = 0; seen_done = 0;
        for (int c = 0; c < 80; c++) begin
            if (wb_val) seen_wb++;
            if (flush_done) seen_done++;
            tick();
        end
        checks++; if (seen_wb !== 0 || seen_done !== 0) begin errors++; $display("FAIL midrst_after got wb %0d done %0d want 0 0", seen_wb, seen_done); end
        do_lookup(32'h0000_1040, 1'b0);
        checks++; if (res_hit !== 1'b0) begin errors++; $display("FAIL midrst_lookup_hit got %b want 0", res_hit); end
        pop();
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_fill(32'h0000_1040, 1'b0, 1'b0);
        do_fill(32'h0000_2140, 1'b1, 1'b1);
        res_rdy = 1'b1;
        lkup_addr = 32'h0000_1040; lkup_val = 1'b1;
        tick();
        checks++; if (res_val !== 1'b1 || res_hit !== 1'b1 || res_way !== 1'b0) begin errors++; $display("FAIL b2b_0 got val %b hit %b way %0d want 1 1 0", res_val, res_hit, res_way); end
        lkup_addr = 32'h0000_2140;
        tick();
        checks++; if (res_val !== 1'b1 || res_hit !== 1'b1 || res_way !== 1'b1) begin errors++; $display("FAIL b2b_1 got val %b hit %b way %0d want 1 1 1", res_val, res_hit, res_way); end
        lkup_addr = 32'h0000_5040;
        tick();
        checks++; if (res_val !== 1'b1 || res_hit !== 1'b0 || res_way !== 1'b1 || res_victim_dirty !== 1'b0) begin errors++; $display("FAIL b2b_2 got val %b hit %b way %0d vd %b want 1 0 1 0", res_val, res_hit, res_way, res_victim_dirty); end
        lkup_val = 1'b0;
        tick();
        checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", res_val); end
        res_rdy = 1'b0;
    endtask

    task automatic test_flush_invalidate();
        logic       exp_hit;
        logic [0:0] exp_way;
`ifdef FLUSH_INVALIDATE_EN
        exp_hit = 1'b0; exp_way = 1'b0;
`else
        exp_hit = 1'b1; exp_way = 1'b1;
`endif
        do_reset();
        do_fill(32'h0000_1040, 1'b0, 1'b0);
        do_lookup(32'h0000_1044, 1'b1);
        pop();
        do_fill(32'h0000_2040, 1'b1, 1'b0);
        run_flush(0, 200);
        checks++; if (done_n !== 1 || wb_n !== 1) begin errors++; $display("FAIL inv_flush got done %0d wb %0d want 1 1", done_n, wb_n); end
        checks++; if (wb_log[0] !== 32'h0000_1040) begin errors++; $display("FAIL inv_wb_addr got %h want 00001040", wb_log[0]); end
        do_lookup(32'h0000_2040, 1'b0);
        checks++; if (res_hit !== exp_hit || res_way !== exp_way) begin errors++; $display("FAIL inv_lookup got hit %b way %0d want %b %0d", res_hit, res_way, exp_hit, exp_way); end
        pop();
    endtask

    initial begin
        test_reset();
        test_lookup_miss();
        test_hit_victim();
        test_backpressure();
        test_flush();
        test_reset_mid_flush();
        test_back_to_back();
        test_flush_invalidate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
